audio_rx_slave: RTL
===================

// Module: audio_rx_slave
// PURPOSE
//  Slave-side I2S-style serial audio receiver: accepts externally generated BCK/LRCK/DATA
//  (left-justified, MSB first, 16 bits per channel half) and deserializes them to parallel L/R words.
//  Sits at the far end of the codec-style serial link: tape/line-in bridges, loopback checks of the audio output path.
//  All logic runs in the iCLK_18_4 domain; serial inputs are oversampled (BCK <= iCLK_18_4/8).
// PARAMETERS
//  DATA_WIDTH   16  bits captured per channel half
//  LEFT_LEVEL   1   iLRCK level that marks the left-channel half
//  LOCK_FRAMES  4   consecutive good frames required to assert oLOCKED (1..15)
// PORTS
//  iCLK_18_4  in   1   system clock, 18.432 MHz
//  iRST_N     in   1   reset, asynchronous, active-low
//  iBCK       in   1   serial bit clock from the external master (asynchronous)
//  iLRCK      in   1   word/channel select from the external master (asynchronous)
//  iDATA      in   1   serial data, changes on BCK falling edge
//  iERR_CLR   in   1   synchronous 1-cycle clear of oFRAME_ERR
//  oLEFT      out  16  last complete left sample
//  oRIGHT     out  16  last complete right sample (same frame as oLEFT)
//  oVALID     out  1   1-cycle strobe: oLEFT/oRIGHT updated this cycle
//  oFRAME_ERR out  1   sticky: a channel half ended with fewer than DATA_WIDTH bits
//  oLOCKED    out  1   LOCK_FRAMES consecutive good frames seen since last error/reset
// BEHAVIOUR
//  Reset: all outputs 0, shift reg/bit counter/lock counter 0, state HUNT; reset mid-frame discards the partial frame.
//  Input sync: iBCK/iLRCK/iDATA each pass a 2-flop synchronizer; a third flop gives edge detect.
//   bck_rise = sync BCK 0->1; lr_edge = sync LRCK change. iDATA uses the same delay, so it stays aligned with BCK.
//  Bit capture on bck_rise: shift = {shift[DATA_WIDTH-2:0], data}, but only while bit_cnt < DATA_WIDTH;
//   bit_cnt increments, saturating at 31. Bits beyond DATA_WIDTH are ignored (no error).
//  FSM states: HUNT, LEFT, RIGHT.
//   HUNT : ignore data; on lr_edge to LEFT_LEVEL -> LEFT; on lr_edge to other level stay HUNT.
//   LEFT : on lr_edge: if bit_cnt>=DATA_WIDTH latch shift->left_hold, lgood=1, else lgood=0; -> RIGHT.
//   RIGHT: on lr_edge: if lgood && bit_cnt>=DATA_WIDTH -> good frame, else bad frame; -> LEFT.
//   Every lr_edge clears bit_cnt to 0 (shift reg not cleared; it is overwritten).
//  Good frame (same cycle as closing lr_edge): oLEFT<=left_hold, oRIGHT<=shift, oVALID=1 next cycle only,
//   lock_cnt increments (saturating at LOCK_FRAMES); oLOCKED=1 when lock_cnt==LOCK_FRAMES.
//  Bad frame or short LEFT half: oFRAME_ERR<=1, lock_cnt<=0, oLOCKED<=0, oLEFT/oRIGHT held, no oVALID.
//   The short-LEFT error is flagged when the LEFT half closes.
//  Simultaneous lr_edge and bck_rise in one cycle: the edge closes the old half first; the
//   sampled bit becomes bit 0 of the new half (bit_cnt=1 afterwards).
//  iERR_CLR and a new error in the same cycle: error wins (oFRAME_ERR stays 1).
//  Latency: oVALID asserts 4 iCLK_18_4 cycles after the raw iLRCK edge that ends the right half
//   (2 sync + 1 edge + 1 register).
//  LRCK polarity from LEFT_LEVEL only; first frame after reset is always captured from a left half.
// TESTING
//  1. 48 kHz frame (BCK period 12 clk), L=16'hA55A, R=16'h1234 -> oVALID 1 cycle, oLEFT=A55A, oRIGHT=1234, oFRAME_ERR=0.
//  2. Start stimulus mid-right-half after reset -> no oVALID until first full L+R pair; first pair decoded exactly.
//  3. 4 good frames, then a left half with only 12 BCKs -> oLOCKED rises after frame 4, then oFRAME_ERR=1 and oLOCKED=0;
//     oLEFT/oRIGHT keep frame-4 values; pulse iERR_CLR -> oFRAME_ERR=0.
//  4. 24 BCKs per half, L=16'hFFFF then 8 zero bits -> oLEFT=FFFF, no error.
//  5. LRCK edge coincident with BCK rise (skew stimulus) -> MSB still lands in bit 15, values exact.
//  6. Assert iRST_N low mid-left-half, release -> all outputs 0, next complete frame decoded correctly.

Source files
------------

// File: rtl/audio_rx_slave_if.sv
// Serial audio receive link: raw BCK/LRCK/DATA from the external master plus the decoded L/R sample outputs.
// The master modport is the stimulus/consumer side; the slave modport is the receiver.
interface audio_rx_slave_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  iBCK;
    logic                  iLRCK;
    logic                  iDATA;
    logic                  iERR_CLR;
    logic [DATA_WIDTH-1:0] oLEFT;
    logic [DATA_WIDTH-1:0] oRIGHT;
    logic                  oVALID;
    logic                  oFRAME_ERR;
    logic                  oLOCKED;

    modport master (
        output iBCK, iLRCK, iDATA, iERR_CLR,
        input  oLEFT, oRIGHT, oVALID, oFRAME_ERR, oLOCKED
    );

    modport slave (
        input  iBCK, iLRCK, iDATA, iERR_CLR,
        output oLEFT, oRIGHT, oVALID, oFRAME_ERR, oLOCKED
    );
endinterface

// File: rtl/audio_rx_slave.sv
// Slave serial audio receiver: oversamples BCK/LRCK/DATA and deserializes left-justified L/R words.
// Latency 4 clk from the raw closing LRCK edge to oVALID; no backpressure, oVALID is a 1-cycle strobe.
module audio_rx_slave #(
    parameter int DATA_WIDTH  = 16,
    parameter bit LEFT_LEVEL  = 1'b1,
    parameter int LOCK_FRAMES = 4
) (
    input  logic            iCLK_18_4,
    input  logic            iRST_N,
    audio_rx_slave_if.slave bus
);
    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    localparam logic [4:0] FULL_CNT = 5'(DATA_WIDTH);
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

    state_t                state, stateNxt;
    logic [2:0]            bckPipe, lrckPipe;
    logic [1:0]            dataPipe;
    logic                  bckRise, lrEdge, lrLevel, bitIn;
    logic [DATA_WIDTH-1:0] shiftReg, leftHold;
    logic [4:0]            bitCnt;
    logic                  lGood;
    logic [3:0]            lockCnt, lockNxt;
    logic                  halfFull, goodFrame, shortLeft, badFrame, errEvent;

    // Two sync flops, a third for edge detect, then the detected pulses are registered.
    // DATA rides the same depth so bitIn is the level sampled at the BCK rise.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            bckPipe  <= '0;
            lrckPipe <= '0;
            dataPipe <= '0;
            bckRise  <= 1'b0;
            lrEdge   <= 1'b0;
            lrLevel  <= 1'b0;
            bitIn    <= 1'b0;
        end else begin
            bckPipe  <= {bckPipe[1:0], bus.iBCK};
            lrckPipe <= {lrckPipe[1:0], bus.iLRCK};
            dataPipe <= {dataPipe[0], bus.iDATA};
            bckRise  <= bckPipe[1] & ~bckPipe[2];
            lrEdge   <= lrckPipe[1] ^ lrckPipe[2];
            lrLevel  <= lrckPipe[1];
            bitIn    <= dataPipe[1];
        end
    end

    assign halfFull = (bitCnt >= FULL_CNT);
    assign lockNxt  = (lockCnt == LOCK_MAX) ? lockCnt : lockCnt + 4'd1;
    assign errEvent = shortLeft | badFrame;

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) state <= HUNT;
        else         state <= stateNxt;
    end

    always_comb begin
        stateNxt  = state;
        goodFrame = 1'b0;
        shortLeft = 1'b0;
        badFrame  = 1'b0;
        if (lrEdge) begin
            case (state)
                HUNT: begin
                    if (lrLevel == LEFT_LEVEL) stateNxt = LEFT;
                end
                LEFT: begin
                    shortLeft = !halfFull;
                    stateNxt  = RIGHT;
                end
                RIGHT: begin
                    if (lGood && halfFull) goodFrame = 1'b1;
                    else                   badFrame  = 1'b1;
                    stateNxt = LEFT;
                end
                default: stateNxt = HUNT;
            endcase
        end
    end

    // A BCK rise coincident with an LRCK edge belongs to the new half: the old half
    // is judged on the pre-shift contents, and the new bit starts the count at 1.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            shiftReg       <= '0;
            leftHold       <= '0;
            bitCnt         <= '0;
            lGood          <= 1'b0;
            lockCnt        <= '0;
            bus.oLEFT      <= '0;
            bus.oRIGHT     <= '0;
            bus.oVALID     <= 1'b0;
            bus.oFRAME_ERR <= 1'b0;
            bus.oLOCKED    <= 1'b0;
        end else begin
            if (lrEdge)
                bitCnt <= bckRise ? 5'd1 : 5'd0;
            else if (bckRise && bitCnt != 5'd31)
                bitCnt <= bitCnt + 5'd1;

            if (bckRise && (lrEdge || !halfFull))
                shiftReg <= {shiftReg[DATA_WIDTH-2:0], bitIn};

            if (lrEdge && state == LEFT) begin
                lGood <= halfFull;
                if (halfFull) leftHold <= shiftReg;
            end

            bus.oVALID <= goodFrame;
            if (goodFrame) begin
                bus.oLEFT   <= leftHold;
                bus.oRIGHT  <= shiftReg;
                lockCnt     <= lockNxt;
                bus.oLOCKED <= (lockNxt == LOCK_MAX);
            end

            if (errEvent) begin
                bus.oFRAME_ERR <= 1'b1;
                lockCnt        <= '0;
                bus.oLOCKED    <= 1'b0;
            end else if (bus.iERR_CLR) begin
                bus.oFRAME_ERR <= 1'b0;
            end
        end
    end
endmodule
